// File: rtl/ram_resp_pkg.sv
// Shared types and constants for the memory-side responder.
package ram_resp_pkg;

  localparam int unsigned LATENCY_MAX = 15;
  localparam int unsigned CNT_W       = $clog2(LATENCY_MAX + 1);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    OP_FETCH = 2'd0,
    OP_READ  = 2'd1,
    OP_WRITE = 2'd2
  } op_e;

endpackage

// File: rtl/ram_responder_array.sv
// Single-port storage array; write or read happens only on the enable strobe.
// Fetch and data reads land in separate output registers so each holds independently.
module ram_array #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_i,
  input  logic              we_i,
  input  logic              to_ins_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] ins_o,
  output logic [DATA_W-1:0] rdata_o
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Contents are never reset.
  always_ff @(posedge clk) begin
    if (en_i && we_i) mem_q[addr_i] <= wdata_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ins_o   <= '0;
      rdata_o <= '0;
    end else if (en_i && !we_i) begin
      if (to_ins_i) ins_o   <= mem_q[addr_i];
      else          rdata_o <= mem_q[addr_i];
    end
  end

endmodule

// File: rtl/ram_responder.sv
// Fixed-latency memory responder: serialises fetch and load/store requests through
// one-deep pending slots and answers each after LATENCY edges.
module ram_responder
  import ram_resp_pkg::*;
#(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_ram_in,
  input  logic [ADDR_W-1:0] pc_addr,
  input  logic              ram_en,
  input  logic              ram_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] ins,
  output logic              en_ram_out,
  output logic [DATA_W-1:0] rdata,
  output logic              rd_valid,
  output logic              wr_done,
  output logic              busy,
  output logic              req_drop
);

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  op_e               op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  logic              fslot_vld_q;
  logic [ADDR_W-1:0] fslot_addr_q;
  logic              dslot_vld_q;
  logic              dslot_we_q;
  logic [ADDR_W-1:0] dslot_addr_q;
  logic [DATA_W-1:0] dslot_wdata_q;

  logic idle_c, resp_c;
  logic take_pd_c, take_nd_c, take_pf_c, take_nf_c;
  logic dlatch_c, ddrop_c, flatch_c, fdrop_c;
  logic mem_en_c, mem_we_c, mem_fetch_c;

  // Selection priority: pending data, new data, pending fetch, new fetch.
  always_comb begin
    idle_c      = (state_q == IDLE);
    resp_c      = (state_q == BUSY) && (cnt_q == CNT_W'(LATENCY - 1));
    take_pd_c   = idle_c && dslot_vld_q;
    take_nd_c   = idle_c && !dslot_vld_q && ram_en;
    take_pf_c   = idle_c && !dslot_vld_q && !ram_en && fslot_vld_q;
    take_nf_c   = idle_c && !dslot_vld_q && !ram_en && !fslot_vld_q && en_ram_in;
    dlatch_c    = ram_en && !take_nd_c && (!dslot_vld_q || take_pd_c);
    ddrop_c     = ram_en && !take_nd_c && dslot_vld_q && !take_pd_c;
    flatch_c    = en_ram_in && !take_nf_c && (!fslot_vld_q || take_pf_c);
    fdrop_c     = en_ram_in && !take_nf_c && fslot_vld_q && !take_pf_c;
    mem_en_c    = resp_c && !rst;
    mem_we_c    = (op_q == OP_WRITE);
    mem_fetch_c = (op_q == OP_FETCH);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      op_q          <= OP_FETCH;
      addr_q        <= '0;
      wdata_q       <= '0;
      fslot_vld_q   <= 1'b0;
      fslot_addr_q  <= '0;
      dslot_vld_q   <= 1'b0;
      dslot_we_q    <= 1'b0;
      dslot_addr_q  <= '0;
      dslot_wdata_q <= '0;
      en_ram_out    <= 1'b0;
      rd_valid      <= 1'b0;
      wr_done       <= 1'b0;
      busy          <= 1'b0;
      req_drop      <= 1'b0;
    end else begin
      en_ram_out <= 1'b0;
      rd_valid   <= 1'b0;
      wr_done    <= 1'b0;
      req_drop   <= ddrop_c || fdrop_c;

      // A slot freed by acceptance may be refilled on the same edge.
      if (take_pd_c) dslot_vld_q <= 1'b0;
      if (dlatch_c) begin
        dslot_vld_q   <= 1'b1;
        dslot_we_q    <= ram_we;
        dslot_addr_q  <= d_addr;
        dslot_wdata_q <= wdata;
      end
      if (take_pf_c) fslot_vld_q <= 1'b0;
      if (flatch_c) begin
        fslot_vld_q  <= 1'b1;
        fslot_addr_q <= pc_addr;
      end

      case (state_q)
        IDLE: begin
          if (take_pd_c || take_nd_c || take_pf_c || take_nf_c) begin
            state_q <= BUSY;
            busy    <= 1'b1;
            cnt_q   <= '0;
            if (take_pd_c) begin
              op_q    <= dslot_we_q ? OP_WRITE : OP_READ;
              addr_q  <= dslot_addr_q;
              wdata_q <= dslot_wdata_q;
            end else if (take_nd_c) begin
              op_q    <= ram_we ? OP_WRITE : OP_READ;
              addr_q  <= d_addr;
              wdata_q <= wdata;
            end else if (take_pf_c) begin
              op_q   <= OP_FETCH;
              addr_q <= fslot_addr_q;
            end else begin
              op_q   <= OP_FETCH;
              addr_q <= pc_addr;
            end
          end
        end
        BUSY: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (resp_c) begin
            state_q    <= IDLE;
            busy       <= 1'b0;
            en_ram_out <= (op_q == OP_FETCH);
            rd_valid   <= (op_q == OP_READ);
            wr_done    <= (op_q == OP_WRITE);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  ram_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_array (
    .clk      (clk),
    .rst      (rst),
    .en_i     (mem_en_c),
    .we_i     (mem_we_c),
    .to_ins_i (mem_fetch_c),
    .addr_i   (addr_q),
    .wdata_i  (wdata_q),
    .ins_o    (ins),
    .rdata_o  (rdata)
  );

endmodule
